// File: rtl/niosii_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the NIOS II input PIO.
// The CPU/bridge side uses the master modport and the PIO uses the slave modport.
interface niosii_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/niosii_pio_in_edge.sv
// Avalon-MM input PIO: synchronised level register, sticky edge capture and maskable IRQ.
// Optional per-bit debounce filter is compiled in with `define PIO_IN_DEBOUNCE_EN.
module niosii_pio_in_edge #(
    parameter int WIDTH           = 18,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    niosii_pio_in_edge_if.slave    bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_RSVD    = 2'd1,
        REG_IRQMASK = 2'd2,
        REG_EDGECAP = 2'd3
    } reg_addr_e;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clear_bits;
    logic [1:0]       warm;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wdata;

    // Upper write-data bits are ignored when WIDTH < 32.
    assign unused_wdata = ^bus.writedata;

    assign wr_en = bus.chipselect & ~bus.write_n;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes sync1 -> sync2 a real two-stage chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            filt_d <= '0;
            warm   <= '0;
        end else begin
            sync1  <= in_port;
            sync2  <= sync1;
            filt_d <= filtered;
            if (warm != 2'd3)
                warm <= warm + 2'd1;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] db_cnt [WIDTH];

    // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
    // explicitly; a real memory would not be.
    always_ff @(posedge clk) begin
        if (reset) begin
            filtered <= '0;
            for (int i = 0; i < WIDTH; i++)
                db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] != filtered[i]) begin
                    if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        filtered[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    always_comb filtered = sync2;
`endif

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        edges = '0;
        if (EDGE_TYPE == 0)
            edges = filtered & ~filt_d;
        else if (EDGE_TYPE == 1)
            edges = ~filtered & filt_d;
        else
            edges = filtered ^ filt_d;
        // Pipeline fill after reset must not look like an input edge.
        if (warm != 2'd3)
            edges = '0;
    end

    always_comb begin
        clear_bits = '0;
        if (wr_en && bus.address == REG_EDGECAP)
            clear_bits = bus.writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_next = '0;
        case (bus.address)
            REG_DATA:    rd_next[WIDTH-1:0] = filtered;
            REG_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
            REG_EDGECAP: rd_next[WIDTH-1:0] = edge_cap;
            default:     rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_cap     <= '0;
            bus.readdata <= '0;
        end else begin
            if (wr_en && bus.address == REG_IRQMASK)
                irq_mask <= bus.writedata[WIDTH-1:0];
            // A new edge in the clearing cycle keeps its bit set.
            edge_cap     <= (edge_cap & ~clear_bits) | edges;
            bus.readdata <= rd_next;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_niosii_pio_in_edge.sv
// Directed bench for niosii_pio_in_edge: three instances cover rising (18-bit),
// any-edge (18-bit) and falling (8-bit) capture on a shared bus with per-instance chipselect.
module tb_niosii_pio_in_edge;

`ifdef PIO_IN_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam int DBC = 4;
    localparam int LAT = DB ? 3 + DBC : 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = '0;
    logic        wn = 1'b1;
    logic [31:0] wd = '0;
    logic        cs0 = 1'b0, cs2 = 1'b0, cs8 = 1'b0;
    logic [17:0] in0 = '0, in2 = '0;
    logic [7:0]  in8 = '0;
    logic        irq0, irq2, irq8;
    logic [31:0] v;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    niosii_pio_in_edge_if bus0 ();
    niosii_pio_in_edge_if bus2 ();
    niosii_pio_in_edge_if bus8 ();

    assign bus0.address = addr;  assign bus0.write_n = wn;  assign bus0.writedata = wd;  assign bus0.chipselect = cs0;
    assign bus2.address = addr;  assign bus2.write_n = wn;  assign bus2.writedata = wd;  assign bus2.chipselect = cs2;
    assign bus8.address = addr;  assign bus8.write_n = wn;  assign bus8.writedata = wd;  assign bus8.chipselect = cs8;

    niosii_pio_in_edge #(.WIDTH(18), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DBC)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .in_port(in0), .irq(irq0));
    niosii_pio_in_edge #(.WIDTH(18), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DBC)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .in_port(in2), .irq(irq2));
    niosii_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DBC)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8), .in_port(in8), .irq(irq8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] data);
        addr = a; wd = data; wn = 1'b0;
        cs0 = (d == 0); cs2 = (d == 2); cs8 = (d == 8);
        tick(1);
        cs0 = 1'b0; cs2 = 1'b0; cs8 = 1'b0; wn = 1'b1;
    endtask

    task automatic rd(input int d, input logic [1:0] a, output logic [31:0] r);
        addr = a;
        tick(1);
        r = (d == 0) ? bus0.readdata : (d == 2) ? bus2.readdata : bus8.readdata;
    endtask

    initial begin
        // Reset with inputs held high
        in0 = 18'h3FFFF; in2 = 18'h00020; in8 = 8'hA5;
        tick(3);
        check("reset_readdata", bus0.readdata, 32'h0);
        check("reset_irq0", {31'b0, irq0}, 32'h0);
        reset = 1'b0;
        tick(12);
        rd(0, 2'd0, v); check("post_reset_data", v, 32'h0003FFFF);
        rd(0, 2'd1, v); check("post_reset_rsvd", v, 32'h0);
        rd(0, 2'd2, v); check("post_reset_mask", v, 32'h0);
        rd(0, 2'd3, v); check("post_reset_edgecap", v, DB ? 32'h0003FFFF : 32'h0);
        check("post_reset_irq0", {31'b0, irq0}, 32'h0);
        wr(0, 2'd3, 32'hFFFFFFFF);
        rd(0, 2'd3, v); check("edgecap_w1c_all", v, 32'h0);

        // 8-bit falling-edge instance: width masking and register map
        wr(8, 2'd2, 32'hFFFFFFFF);
        rd(8, 2'd2, v); check("w8_mask", v, 32'h000000FF);
        rd(8, 2'd0, v); check("w8_data", v, 32'h000000A5);
        wr(8, 2'd0, 32'h0);
        rd(8, 2'd0, v); check("w8_data_ro", v, 32'h000000A5);
        wr(8, 2'd1, 32'hFFFFFFFF);
        rd(8, 2'd1, v); check("w8_rsvd", v, 32'h0);
        rd(8, 2'd3, v); check("w8_cap_none", v, 32'h0);
        check("w8_irq_low", {31'b0, irq8}, 32'h0);
        in8 = 8'hA4;
        tick(12);
        rd(8, 2'd3, v); check("w8_cap_fall", v, 32'h00000001);
        check("w8_irq_high", {31'b0, irq8}, 32'h1);
        rd(8, 2'd0, v); check("w8_data_new", v, 32'h000000A4);

        // Any-edge instance: capture while masked, then unmask
        rd(2, 2'd3, v); check("any_cap_reset", v, DB ? 32'h20 : 32'h0);
        wr(2, 2'd3, 32'hFFFFFFFF);
        in2 = 18'h0;
        tick(12);
        rd(2, 2'd3, v); check("any_cap_fall", v, 32'h00000020);
        check("any_irq_masked", {31'b0, irq2}, 32'h0);
        wr(2, 2'd2, 32'h20);
        check("any_irq_unmask", {31'b0, irq2}, 32'h1);

        // Rising instance: exact capture latency, then clear
        in0 = 18'h3FFFE;
        tick(12);
        wr(0, 2'd2, 32'h1);
        check("rise_fall_ignored", {31'b0, irq0}, 32'h0);
        in0 = 18'h3FFFF;
        for (int e = 1; e <= LAT; e++) begin
            tick(1);
            check($sformatf("rise_lat_e%0d", e), {31'b0, irq0}, (e == LAT) ? 32'h1 : 32'h0);
        end
        rd(0, 2'd3, v); check("rise_cap", v, 32'h1);
        wr(0, 2'd3, 32'h1);
        check("w1c_irq", {31'b0, irq0}, 32'h0);
        rd(0, 2'd3, v); check("w1c_cap", v, 32'h0);

        // Clear and new edge on bit 3 in the same cycle; bit 0 must survive
        in0 = 18'h3FFF6;
        tick(12);
        rd(0, 2'd3, v); check("fall_only", v, 32'h0);
        in0 = 18'h3FFF7;
        tick(12);
        rd(0, 2'd3, v); check("bit0_cap", v, 32'h1);
        in0 = 18'h3FFFF;
        tick(LAT - 1);
        wr(0, 2'd3, 32'h8);
        rd(0, 2'd3, v); check("edge_wins", v, 32'h9);
        check("edge_wins_irq", {31'b0, irq0}, 32'h1);

`ifdef PIO_IN_DEBOUNCE_EN
        in0 = 18'h3FFFB;
        tick(12);
        wr(0, 2'd3, 32'hFFFFFFFF);
        rd(0, 2'd3, v); check("db_pre_cap", v, 32'h0);
        in0 = 18'h3FFFF;
        tick(3);
        in0 = 18'h3FFFB;
        tick(12);
        rd(0, 2'd0, v); check("db_short_data", v, 32'h0003FFFB);
        rd(0, 2'd3, v); check("db_short_cap", v, 32'h0);
        in0 = 18'h3FFFF;
        tick(6);
        tick(4);
        rd(0, 2'd0, v); check("db_long_data", v, 32'h0003FFFF);
        rd(0, 2'd3, v); check("db_long_cap", v, 32'h4);
`endif

        // Reset mid-operation overrides a pending write
        reset = 1'b1; addr = 2'd2; wd = 32'hFFFFFFFF; wn = 1'b0; cs0 = 1'b1;
        tick(1);
        check("midreset_irq", {31'b0, irq0}, 32'h0);
        check("midreset_readdata", bus0.readdata, 32'h0);
        cs0 = 1'b0; wn = 1'b1; reset = 1'b0;
        rd(0, 2'd2, v); check("midreset_mask", v, 32'h0);
        rd(0, 2'd3, v); check("midreset_cap", v, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
